regfile_scoreboard: RTL

- Parametrised successor to the datapath's 2-read/1-write register file, sized for the pipelined datapath.
- Adds configurable data width, register count and number of read ports.
- Adds same-cycle write-to-read bypass and a per-register pending-write scoreboard, so the decode stage can detect RAW/WAW hazards and stall.
- Sits between decode (reads, issue) and writeback (writes).

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 58 +++++
 rtl/regfile_scoreboard.sv | 79 +++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register file with pending-write scoreboard.
// Holds the default geometry, the hard-wired zero register and port slice addressing.
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int ZERO_REG   = 0;

  // Low bit of port `port` inside a packed bus of `width`-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
// Also produces the WAW issue stall and a running count of pending registers.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [2**ADDR_W-1:0]  busy,
  output logic                  iss_stall,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int NREGS = 2**ADDR_W;

  logic              wr_hit;
  logic              iss_req;
  logic              eff_busy;
  logic              do_set;
  logic              do_clr;
  logic [NREGS-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  always_comb begin
    wr_hit    = wr_en && (wr_addr != ADDR_W'(ZERO_REG));
    iss_req   = iss_en && (iss_addr != ADDR_W'(ZERO_REG));
    // A writeback landing this cycle frees its register for a new producer.
    eff_busy  = busy[iss_addr] && !(wr_en && (wr_addr == iss_addr));
    iss_stall = !rst && iss_req && eff_busy;
    do_set    = iss_req && !eff_busy;
    do_clr    = wr_hit && busy[wr_addr];

    // Clear first so that a same-address issue leaves the bit set.
    busy_nxt = busy;
    if (wr_hit) busy_nxt[wr_addr] = 1'b0;
    if (do_set) busy_nxt[iss_addr] = 1'b1;

    cnt_nxt = busy_cnt;
    if (do_set && !do_clr)      cnt_nxt = busy_cnt + (ADDR_W+1)'(1);
    else if (do_clr && !do_set) cnt_nxt = busy_cnt - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with same-cycle write bypass and a pending-write scoreboard.
// Reads are combinational; writes and scoreboard updates occur on the rising edge.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD*DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]         rd_busy,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      iss_en,
  input  logic [ADDR_W-1:0]         iss_addr,
  output logic                      iss_stall,
  output logic [ADDR_W:0]           busy_cnt
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic              wr_hit;

  assign wr_hit = wr_en && (wr_addr != ADDR_W'(ZERO_REG));

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .busy      (busy),
    .iss_stall (iss_stall),
    .busy_cnt  (busy_cnt)
  );

  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              pend;

    assign addr = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];

    always_comb begin
      data = '0;
      pend = 1'b0;
      if (!rst && (addr != ADDR_W'(ZERO_REG))) begin
        if (wr_en && (wr_addr == addr)) begin
          data = wr_data;
        end else begin
          data = regs[addr];
          pend = busy[addr];
        end
      end
    end

    assign rd_data[slice_lo(i, DATA_W) +: DATA_W] = data;
    assign rd_busy[i] = pend;
  end

endmodule
